// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry-ID sizing and instruction kinds.
package rob_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int ROB_SIZE  = 2 ** ROB_WIDTH;

    // What an entry does when it reaches the head and commits
    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2
    } kind_e;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order writeback from the RS and
// LSB, in-order commit, and mispredict detection at commit with a full flush.
module rob
    import rob_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] alloc_id,
    input  logic                 dec_ready,
    input  logic [1:0]           dec_kind,
    input  logic [4:0]           dec_rd,
    input  logic [31:0]          dec_pred_pc,
    input  logic                 rs_ready,
    input  logic [ROB_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]          rs_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] qry_j_id,
    output logic                 qry_j_ready,
    output logic [31:0]          qry_j_value,
    input  logic [ROB_WIDTH-1:0] qry_k_id,
    output logic                 qry_k_ready,
    output logic [31:0]          qry_k_value,
    output logic                 commit_reg,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_value,
    output logic [ROB_WIDTH-1:0] commit_id,
    output logic                 commit_store,
    output logic                 clear,
    output logic [31:0]          redirect_pc
);

    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);

    // Per-entry state; busy/done carry reset, the payload does not need it
    logic [ROB_SIZE-1:0] busy_q, done_q;
    kind_e               kind_q  [ROB_SIZE];
    logic [4:0]          rd_q    [ROB_SIZE];
    logic [31:0]         value_q [ROB_SIZE];
    logic [31:0]         pred_q  [ROB_SIZE];

    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_reg_q, commit_store_q, clear_q;
    logic [4:0]           commit_rd_q;
    logic [31:0]          commit_value_q, redirect_q;
    logic [ROB_WIDTH-1:0] commit_id_q;

    logic commit_ok, mispredict, active, do_commit, flush, do_alloc, wb_rs, wb_lsb;

    assign rob_full     = (count_q == FULL_CNT);
    assign alloc_id     = tail_q;
    assign commit_reg   = commit_reg_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_id    = commit_id_q;
    assign commit_store = commit_store_q;
    assign clear        = clear_q;
    assign redirect_pc  = redirect_q;

    // Operand lookup: a broadcast in flight counts as ready, RS wins over LSB
    assign qry_j_ready = done_q[qry_j_id] || (rs_ready && rs_rob_id == qry_j_id) ||
                         (lsb_ready && lsb_rob_id == qry_j_id);
    assign qry_j_value = (rs_ready  && rs_rob_id  == qry_j_id) ? rs_value  :
                         (lsb_ready && lsb_rob_id == qry_j_id) ? lsb_value : value_q[qry_j_id];
    assign qry_k_ready = done_q[qry_k_id] || (rs_ready && rs_rob_id == qry_k_id) ||
                         (lsb_ready && lsb_rob_id == qry_k_id);
    assign qry_k_value = (rs_ready  && rs_rob_id  == qry_k_id) ? rs_value  :
                         (lsb_ready && lsb_rob_id == qry_k_id) ? lsb_value : value_q[qry_k_id];

    // Cycle control: commit decision uses registered done only (no writeback bypass),
    // and the cycle after a flush ignores all inputs while upstream clears
    always_comb begin
        commit_ok  = busy_q[head_q] && done_q[head_q];
        mispredict = (kind_q[head_q] == KIND_BRANCH) && (value_q[head_q] != pred_q[head_q]);
        active     = rdy_in && !clear_q;
        do_commit  = active && commit_ok;
        flush      = do_commit && mispredict;
        do_alloc   = active && !flush && dec_ready && !rob_full;
        wb_rs      = active && !flush && rs_ready  && busy_q[rs_rob_id];
        wb_lsb     = active && !flush && lsb_ready && busy_q[lsb_rob_id];
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit) head_d = head_q + ROB_WIDTH'(1);
            if (do_alloc)  tail_d = tail_q + ROB_WIDTH'(1);
            count_d = count_q + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_commit);
        end
    end

    // Pointers, entry status bits and the registered commit/flush outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            commit_reg_q   <= 1'b0;
            commit_store_q <= 1'b0;
            clear_q        <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_id_q    <= '0;
            redirect_q     <= '0;
        end else if (rdy_in) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_reg_q   <= 1'b0;
            commit_store_q <= 1'b0;
            clear_q        <= 1'b0;
            if (do_commit) begin
                commit_id_q <= head_q;
                case (kind_q[head_q])
                    KIND_REG: begin
                        commit_reg_q   <= 1'b1;
                        commit_rd_q    <= rd_q[head_q];
                        commit_value_q <= value_q[head_q];
                    end
                    KIND_STORE: commit_store_q <= 1'b1;
                    default: begin
                        if (mispredict) begin
                            clear_q    <= 1'b1;
                            redirect_q <= value_q[head_q];
                        end
                    end
                endcase
            end
            if (flush) begin
                busy_q <= '0;
            end else begin
                if (do_commit) busy_q[head_q] <= 1'b0;
                if (do_alloc) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                end
                if (wb_lsb) done_q[lsb_rob_id] <= 1'b1;
                if (wb_rs)  done_q[rs_rob_id]  <= 1'b1;
            end
        end
    end

    // Entry payload: decode fields on allocation, results on writeback (RS last so it wins)
    always_ff @(posedge clk_in) begin
        if (do_alloc) begin
            kind_q[tail_q] <= kind_e'(dec_kind);
            rd_q[tail_q]   <= dec_rd;
            pred_q[tail_q] <= dec_pred_pc;
        end
        if (wb_lsb) value_q[lsb_rob_id] <= lsb_value;
        if (wb_rs)  value_q[rs_rob_id]  <= rs_value;
    end

endmodule

// File: tb/tb_rob.sv
// Randomized and directed bench for the reorder buffer, checked against a
// queue-based program-order model.
module tb_rob;
    import rob_pkg::*;

    logic        clk_in, rst_in, rdy_in;
    logic        rob_full;
    logic [2:0]  alloc_id;
    logic        dec_ready;
    logic [1:0]  dec_kind;
    logic [4:0]  dec_rd;
    logic [31:0] dec_pred_pc;
    logic        rs_ready, lsb_ready;
    logic [2:0]  rs_rob_id, lsb_rob_id;
    logic [31:0] rs_value, lsb_value;
    logic [2:0]  qry_j_id, qry_k_id;
    logic        qry_j_ready, qry_k_ready;
    logic [31:0] qry_j_value, qry_k_value;
    logic        commit_reg, commit_store, clear;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, redirect_pc;
    logic [2:0]  commit_id;

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .alloc_id(alloc_id),
        .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .qry_j_id(qry_j_id), .qry_j_ready(qry_j_ready), .qry_j_value(qry_j_value),
        .qry_k_id(qry_k_id), .qry_k_ready(qry_k_ready), .qry_k_value(qry_k_value),
        .commit_reg(commit_reg), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_id(commit_id), .commit_store(commit_store),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: live entries in program order
    typedef struct {
        logic [2:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pred;
        logic [31:0] val;
        bit          done;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 0;
    bit          m_clr = 0;
    bit          e_reg = 0, e_store = 0, e_clear = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_val = 0, e_redir = 0;
    logic [2:0]  e_id = 0;

    // DUT observations, used by directed scenarios
    int          n_reg = 0, n_store = 0, n_clear = 0, cyc = 0;
    int          obs_rd[$], obs_val[$], obs_cyc[$];
    int          last_store_id = -1;

    task automatic model_reset();
        q.delete();
        m_tail = 0; m_clr = 0;
        e_reg = 0; e_store = 0; e_clear = 0;
        e_rd = 0; e_val = 0; e_redir = 0; e_id = 0;
    endtask

    // One clock edge of architectural behaviour
    task automatic mstep();
        ent_t h;
        bit   full, flush;
        if (!rdy_in) return;
        if (m_clr) begin
            e_reg = 0; e_store = 0; e_clear = 0; m_clr = 0;
            return;
        end
        full = (q.size() == 8);
        flush = 0;
        e_reg = 0; e_store = 0; e_clear = 0;
        if (q.size() > 0 && q[0].done) begin
            h = q.pop_front();
            e_id = h.id;
            if (h.kind == 0) begin
                e_reg = 1; e_rd = h.rd; e_val = h.val;
            end else if (h.kind == 1) begin
                e_store = 1;
            end else if (h.val != h.pred) begin
                e_clear = 1; e_redir = h.val; flush = 1;
            end
        end
        if (flush) begin
            q.delete(); m_tail = 0; m_clr = 1;
            return;
        end
        foreach (q[i]) begin
            if (lsb_ready && lsb_rob_id == q[i].id) begin q[i].val = lsb_value; q[i].done = 1; end
            if (rs_ready  && rs_rob_id  == q[i].id) begin q[i].val = rs_value;  q[i].done = 1; end
        end
        if (dec_ready && !full) begin
            q.push_back('{id: 3'(m_tail), kind: dec_kind, rd: dec_rd, pred: dec_pred_pc, val: 0, done: 0});
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    task automatic qcheck(input string t, input logic [2:0] id, input logic rdy, input logic [31:0] v);
        bit          er;
        logic [31:0] ev;
        int          idx = -1;
        foreach (q[i]) if (q[i].id == id) idx = i;
        if (idx < 0) return;
        er = q[idx].done; ev = q[idx].val;
        if (lsb_ready && lsb_rob_id == id) begin er = 1; ev = lsb_value; end
        if (rs_ready  && rs_rob_id  == id) begin er = 1; ev = rs_value;  end
        chk({t, "_ready"}, 32'(rdy), 32'(er));
        if (er) chk({t, "_value"}, v, ev);
    endtask

    // Check combinational outputs, clock once, advance model, check registered outputs
    task automatic tick();
        #3;
        chk("rob_full", 32'(rob_full), 32'(q.size() == 8));
        chk("alloc_id", 32'(alloc_id), 32'(m_tail));
        if (dec_ready && rdy_in && !m_clr) chk("alloc_while_full", 32'(rob_full), 0);
        qcheck("qry_j", qry_j_id, qry_j_ready, qry_j_value);
        qcheck("qry_k", qry_k_id, qry_k_ready, qry_k_value);
        @(posedge clk_in);
        mstep();
        #1;
        cyc++;
        chk("commit_reg", 32'(commit_reg), 32'(e_reg));
        chk("commit_store", 32'(commit_store), 32'(e_store));
        chk("clear", 32'(clear), 32'(e_clear));
        if (e_reg) begin
            chk("commit_rd", 32'(commit_rd), 32'(e_rd));
            chk("commit_value", commit_value, e_val);
            chk("commit_id", 32'(commit_id), 32'(e_id));
        end
        if (e_store) chk("store_id", 32'(commit_id), 32'(e_id));
        if (e_clear) chk("redirect_pc", redirect_pc, e_redir);
        if (commit_reg) begin
            n_reg++; obs_rd.push_back(int'(commit_rd)); obs_val.push_back(int'(commit_value));
            obs_cyc.push_back(cyc);
        end
        if (commit_store) begin n_store++; last_store_id = int'(commit_id); end
        if (clear) n_clear++;
    endtask

    task automatic idle();
        dec_ready = 0; rs_ready = 0; lsb_ready = 0;
    endtask

    task automatic alloc(input int kind, input int rd, input logic [31:0] pred);
        idle();
        dec_ready = 1; dec_kind = 2'(kind); dec_rd = 5'(rd); dec_pred_pc = pred;
        tick();
        dec_ready = 0;
    endtask

    task automatic rs_bc(input int id, input logic [31:0] v);
        idle();
        rs_ready = 1; rs_rob_id = 3'(id); rs_value = v;
        tick();
        rs_ready = 0;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_commit_reg"}, 32'(commit_reg), 0);
        chk({t, "_commit_store"}, 32'(commit_store), 0);
        chk({t, "_clear"}, 32'(clear), 0);
        chk({t, "_commit_rd"}, 32'(commit_rd), 0);
        chk({t, "_commit_value"}, commit_value, 0);
        chk({t, "_commit_id"}, 32'(commit_id), 0);
        chk({t, "_redirect_pc"}, redirect_pc, 0);
        chk({t, "_rob_full"}, 32'(rob_full), 0);
        chk({t, "_alloc_id"}, 32'(alloc_id), 0);
    endtask

    task automatic rnd_cycle();
        int cand[$];
        int a, b;
        rdy_in      = ($urandom_range(15) != 0);
        dec_ready   = !m_clr && q.size() < 8 && ($urandom_range(1) == 1);
        dec_kind    = 2'($urandom_range(2));
        dec_rd      = 5'($urandom);
        dec_pred_pc = $urandom & 32'hFFFF_FFFC;
        rs_ready = 0; lsb_ready = 0; rs_rob_id = 0; lsb_rob_id = 0;
        rs_value = $urandom; lsb_value = $urandom;
        foreach (q[i]) if (!q[i].done) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(1) == 1) begin
            a = cand[$urandom_range(cand.size() - 1)];
            rs_ready = 1; rs_rob_id = q[a].id;
            if (q[a].kind == 2) rs_value = ($urandom_range(3) == 0) ? q[a].pred + 4 : q[a].pred;
        end else if (q.size() < 8 && $urandom_range(7) == 0) begin
            rs_ready = 1; rs_rob_id = 3'(m_tail);   // stray broadcast to a free entry
        end
        if (cand.size() > 0 && $urandom_range(1) == 1) begin
            b = cand[$urandom_range(cand.size() - 1)];
            if (!(rs_ready && q[b].id == rs_rob_id)) begin
                lsb_ready = 1; lsb_rob_id = q[b].id;
            end
        end
        qry_j_id = 3'($urandom_range(7));
        qry_k_id = 3'($urandom_range(7));
        tick();
    endtask

    int r0, s0, c0;

    initial begin
        rst_in = 0; rdy_in = 1;
        idle();
        dec_kind = 0; dec_rd = 0; dec_pred_pc = 0;
        rs_rob_id = 0; rs_value = 0; lsb_rob_id = 0; lsb_value = 0;
        qry_j_id = 0; qry_k_id = 0;
        #2;
        chk_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 1;

        // In-order commit of out-of-order results
        obs_rd.delete(); obs_val.delete(); obs_cyc.delete();
        alloc(0, 1, 0); alloc(0, 2, 0); alloc(0, 3, 0);
        rs_bc(1, 32'h22); rs_bc(0, 32'h11); rs_bc(2, 32'h33);
        idle(); repeat (3) tick();
        chk("order_count", obs_rd.size(), 3);
        if (obs_rd.size() == 3) begin
            chk("order_rd0", obs_rd[0], 1);  chk("order_val0", obs_val[0], 32'h11);
            chk("order_rd1", obs_rd[1], 2);  chk("order_val1", obs_val[1], 32'h22);
            chk("order_rd2", obs_rd[2], 3);  chk("order_val2", obs_val[2], 32'h33);
            chk("order_back2back", obs_cyc[2] - obs_cyc[0], 2);
        end

        // Mispredicted branch flushes younger finished entries
        r0 = n_reg; c0 = n_clear;
        alloc(2, 0, 32'h100); alloc(0, 4, 0); alloc(0, 5, 0);
        idle(); rs_ready = 1; rs_rob_id = 4; rs_value = 32'h44;
        lsb_ready = 1; lsb_rob_id = 5; lsb_value = 32'h55;
        tick();
        rs_bc(3, 32'h104);
        idle(); tick();
        chk("mispredict_clear", 32'(clear), 1);
        chk("mispredict_redirect", redirect_pc, 32'h104);
        chk("flush_alloc_id", 32'(alloc_id), 0);
        chk("flush_not_full", 32'(rob_full), 0);
        repeat (4) tick();
        chk("flush_clear_once", n_clear - c0, 1);
        chk("flush_no_younger", n_reg - r0, 0);

        // Fill to full, retire one, refill across the wrap
        for (int i = 0; i < 8; i++) alloc(0, 8 + i, 0);
        chk("full_flag", 32'(rob_full), 1);
        chk("full_alloc_id", 32'(alloc_id), 0);
        rs_bc(0, 32'h80);
        idle(); tick();
        alloc(0, 20, 0);
        chk("refull_flag", 32'(rob_full), 1);
        chk("wrap_alloc_id", 32'(alloc_id), 1);
        for (int i = 1; i <= 8; i++) rs_bc(i % 8, 32'h80 + 32'(i));
        idle(); repeat (3) tick();

        // Correctly predicted branch retires silently
        r0 = n_reg; s0 = n_store; c0 = n_clear;
        alloc(2, 0, 32'h200);
        rs_bc(1, 32'h200);
        idle(); repeat (3) tick();
        chk("pred_ok_no_pulse", (n_reg - r0) + (n_store - s0) + (n_clear - c0), 0);
        chk("pred_ok_alloc_id", 32'(alloc_id), 2);

        // Same-cycle query bypass and dual broadcast
        for (int i = 0; i < 4; i++) alloc(0, 24 + i, 0);
        idle(); qry_j_id = 4; qry_k_id = 0;
        rs_ready = 1; rs_rob_id = 4; rs_value = 32'hABCD;
        lsb_ready = 1; lsb_rob_id = 5; lsb_value = 32'h5555;
        #1;
        chk("bypass_ready", 32'(qry_j_ready), 1);
        chk("bypass_value", qry_j_value, 32'hABCD);
        tick();
        idle(); qry_k_id = 5;
        #1;
        chk("lsb_capt_ready", 32'(qry_k_ready), 1);
        chk("lsb_capt_value", qry_k_value, 32'h5555);
        rs_bc(2, 32'h2); rs_bc(3, 32'h3);
        idle(); repeat (5) tick();

        // Store completed by the LSB
        s0 = n_store;
        alloc(1, 0, 0);
        idle(); lsb_ready = 1; lsb_rob_id = 6; lsb_value = 32'h0;
        tick();
        idle(); repeat (2) tick();
        chk("store_pulse", n_store - s0, 1);
        chk("store_commit_id", last_store_id, 6);

        // Global stall freezes everything, then resumes
        r0 = n_reg;
        alloc(0, 9, 0);
        rs_bc(7, 32'h77);
        rdy_in = 0; dec_ready = 1; dec_kind = 0;
        rs_ready = 1; rs_rob_id = 7; rs_value = 32'hDEAD;
        repeat (3) tick();
        chk("stall_no_pulse", n_reg - r0, 0);
        chk("stall_alloc_id", 32'(alloc_id), 0);
        rdy_in = 1; idle(); tick();
        chk("resume_pulse", n_reg - r0, 1);
        chk("resume_rd", 32'(commit_rd), 9);
        chk("resume_value", commit_value, 32'h77);

        // Random traffic
        for (int i = 0; i < 1500; i++) rnd_cycle();

        // Asynchronous reset mid-stream
        #2 rst_in = 0;
        #1 chk_zero("async_reset");
        model_reset();
        rdy_in = 1; idle();
        #1 rst_in = 1;
        @(posedge clk_in); #1;
        for (int i = 0; i < 600; i++) rnd_cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
